// File: rtl/bambu_slave_loader_if.sv
// Loader <-> HLS accelerator link: slave memory port plus start/done handshake.
// master = loader side, slave = accelerator/memory side.
interface bambu_slave_loader_if #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SIZE_W   = 4,
    parameter int CHANNELS = 2
);
    logic                         start_port;
    logic                         done_port;
    logic [CHANNELS-1:0]          S_oe_ram;
    logic [CHANNELS-1:0]          S_we_ram;
    logic [CHANNELS*ADDR_W-1:0]   S_addr_ram;
    logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram;
    logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size;
    logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram;
    logic [CHANNELS-1:0]          Sout_DataRdy;

    modport master (
        output start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        input  done_port, Sout_Rdata_ram, Sout_DataRdy
    );

    modport slave (
        input  start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
        output done_port, Sout_Rdata_ram, Sout_DataRdy
    );
endinterface

// File: rtl/bambu_slave_loader.sv
// Host-side sequencer for an HLS `main` core: byte-stream preload, start/done
// handshake with cycle counting and timeout, then byte-stream readback.
module bambu_slave_loader #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SIZE_W   = 4,
    parameter int CHANNELS = 2,
    parameter int TIMEOUT  = 200000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_go,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              job_done,
    output logic              timeout,
    output logic [31:0]       cycles,
    bambu_slave_loader_if.master acc
);
    localparam logic [31:0] TMO_LIM = 32'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, LD_ISSUE, LD_WAIT, START, RUN, RD_ISSUE, RD_WAIT, RD_OUT, FIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              ld_last_q, ld_last_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       cycles_q, cycles_d;

    logic rdy0, we0, oe0;

    assign rdy0 = acc.Sout_DataRdy[0];

    always_comb begin
        state_d   = state_q;
        ld_ptr_d  = ld_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rem_d     = rem_q;
        ld_last_d = ld_last_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        case (state_q)
            IDLE: if (cmd_go) begin
                ld_ptr_d  = load_base;
                rd_ptr_d  = rd_base;
                rem_d     = rd_len;
                timeout_d = 1'b0;
                state_d   = LD_ISSUE;
            end
            LD_ISSUE: if (in_valid) begin
                ld_last_d = in_last;
                state_d   = LD_WAIT;
            end
            LD_WAIT: if (rdy0) begin
                ld_ptr_d = ld_ptr_q + ADDR_W'(1);
                state_d  = ld_last_q ? START : LD_ISSUE;
            end
            START: begin
                cycles_d = 32'd1;
                state_d  = RUN;
            end
            // The cycle done_port is seen is itself counted.
            RUN: begin
                cycles_d = cycles_q + 32'd1;
                if (acc.done_port) begin
                    state_d = (rem_q == '0) ? FIN : RD_ISSUE;
                end else if (cycles_q + 32'd1 == TMO_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: if (rdy0) begin
                rdata_d = acc.Sout_Rdata_ram[7:0];
                state_d = RD_OUT;
            end
            RD_OUT: if (out_ready) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                rem_d    = rem_q - (ADDR_W+1)'(1);
                state_d  = (rem_q == (ADDR_W+1)'(1)) ? FIN : RD_ISSUE;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ld_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rem_q     <= '0;
            ld_last_q <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            ld_ptr_q  <= ld_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rem_q     <= rem_d;
            ld_last_q <= ld_last_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

    // Handshake outputs decode straight from the registered state.
    assign in_ready   = (state_q == LD_ISSUE);
    assign out_valid  = (state_q == RD_OUT);
    assign out_data   = rdata_q;
    assign out_last   = out_valid && (rem_q == (ADDR_W+1)'(1));
    assign busy       = (state_q != IDLE);
    assign job_done   = (state_q == FIN);
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;
    assign we0        = in_ready && in_valid;
    assign oe0        = (state_q == RD_ISSUE);

    always_comb begin
        acc.start_port      = (state_q == START);
        acc.S_we_ram        = '0;
        acc.S_oe_ram        = '0;
        acc.S_addr_ram      = '0;
        acc.S_Wdata_ram     = '0;
        acc.S_data_ram_size = '0;
        acc.S_we_ram[0]     = we0;
        acc.S_oe_ram[0]     = oe0;
        if (we0) begin
            acc.S_addr_ram[ADDR_W-1:0]      = ld_ptr_q;
            acc.S_Wdata_ram[7:0]            = in_data;
            acc.S_data_ram_size[SIZE_W-1:0] = SIZE_W'(8);
        end else if (oe0) begin
            acc.S_addr_ram[ADDR_W-1:0]      = rd_ptr_q;
            acc.S_data_ram_size[SIZE_W-1:0] = SIZE_W'(8);
        end
    end
endmodule

// File: tb/tb_bambu_slave_loader.sv
// Bench for bambu_slave_loader: slave memory + accelerator models, a job table,
// randomized jobs and a mid-job reset, all checked against a reference memory image.
module tb_bambu_slave_loader;
    localparam int AW = 7, DW = 8, SW = 4, CH = 2, TMO = 100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          cmd_go = 0;
    logic [AW-1:0] load_base = 0, rd_base = 0;
    logic [AW:0]   rd_len = 0;
    logic          in_valid = 0, in_last = 0, out_ready = 0;
    logic [7:0]    in_data = 0;
    logic          in_ready, out_valid, out_last, busy, job_done, timeout;
    logic [7:0]    out_data;
    logic [31:0]   cycles;

    bambu_slave_loader_if #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .CHANNELS(CH)) acc();

    bambu_slave_loader #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .CHANNELS(CH), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .cmd_go(cmd_go), .load_base(load_base), .rd_base(rd_base),
        .rd_len(rd_len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .job_done(job_done), .timeout(timeout),
        .cycles(cycles), .acc(acc.master)
    );

    int errors = 0, checks = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 29 + 7);
    endfunction

    // Slave memory: write ack 1 cycle after we, read data 2 cycles after oe.
    logic [7:0]    mem [128];
    logic          init_done = 0, rd_dly;
    logic [AW-1:0] raddr;
    logic [18:0]   wlog [$];
    logic [AW-1:0] rlog [$];
    int            start_cnt = 0, viol = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc.Sout_DataRdy   <= '0;
            acc.Sout_Rdata_ram <= '0;
            rd_dly             <= 1'b0;
            raddr              <= '0;
            if (!init_done) begin
                for (int i = 0; i < 128; i++) mem[i] <= init_byte(i);
                init_done <= 1'b1;
            end
        end else begin
            acc.Sout_DataRdy <= '0;
            rd_dly           <= 1'b0;
            if (acc.S_we_ram[0]) begin
                mem[acc.S_addr_ram[AW-1:0]] <= acc.S_Wdata_ram[7:0];
                acc.Sout_DataRdy[0] <= 1'b1;
                wlog.push_back({acc.S_data_ram_size[SW-1:0], acc.S_addr_ram[AW-1:0], acc.S_Wdata_ram[7:0]});
            end
            if (acc.S_oe_ram[0]) begin
                rd_dly <= 1'b1;
                raddr  <= acc.S_addr_ram[AW-1:0];
                rlog.push_back(acc.S_addr_ram[AW-1:0]);
            end
            if (rd_dly) begin
                acc.Sout_DataRdy[0] <= 1'b1;
                acc.Sout_Rdata_ram  <= {8'hA5, mem[raddr]};
            end
            if (acc.start_port) start_cnt <= start_cnt + 1;
            if (acc.S_oe_ram[1] || acc.S_we_ram[1] || (|acc.S_addr_ram[2*AW-1:AW]) ||
                (|acc.S_Wdata_ram[15:8]) || (|acc.S_data_ram_size[7:4]) ||
                (acc.S_oe_ram[0] && acc.S_we_ram[0]) ||
                ((acc.S_oe_ram[0] || acc.S_we_ram[0]) && acc.S_data_ram_size[3:0] != 4'd8) ||
                (!acc.S_oe_ram[0] && !acc.S_we_ram[0] &&
                 ((|acc.S_addr_ram[AW-1:0]) || (|acc.S_Wdata_ram[7:0]) || (|acc.S_data_ram_size[3:0]))))
                viol <= viol + 1;
        end
    end

    // Accelerator: done_port pulses done_delay cycles after start_port (0 = never).
    int   done_delay = 0;
    int   acnt;
    logic arun;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            arun <= 1'b0;
            acnt <= 0;
        end else if (acc.start_port) begin
            arun <= 1'b1;
            acnt <= 1;
        end else if (arun) begin
            acnt <= acnt + 1;
            if (acc.done_port) arun <= 1'b0;
        end
    end
    assign acc.done_port = arun && (done_delay > 0) && (acnt == done_delay);

    // Reference memory image: what the slave RAM should hold per the load rules.
    logic [7:0] ref_mem [128];
    logic [7:0] jd [$];

    task automatic check_idle(input string nm);
        check(nm, {in_ready, out_valid, out_data, out_last, busy, job_done, timeout,
                   acc.start_port, acc.S_oe_ram, acc.S_we_ram, acc.S_addr_ram,
                   acc.S_Wdata_ram, acc.S_data_ram_size}, 64'd0);
        check({nm, "_cycles"}, cycles, 0);
    endtask

    task automatic run_job(input logic [6:0] lb, input int n, input logic [6:0] rb, input int rl,
                           input int dly, input int bp, input bit dup, input bit gad,
                           input int exp_cyc, input bit exp_tmo);
        int s0, r0, nrd;
        logic [7:0] got [$];
        bit lastq [$];
        bit seen;
        seen = 0;
        done_delay = dly;
        wlog.delete();
        s0 = start_cnt;
        r0 = rlog.size();
        @(negedge clock);
        cmd_go = 1; load_base = lb; rd_base = rb; rd_len = 8'(rl);
        @(negedge clock);
        cmd_go = 0; load_base = 7'h5A;
        check("go_in_ready", in_ready, 1);
        check("go_busy", busy, 1);
        check("go_timeout_clr", timeout, 0);
        fork
            begin
                int i, bud;
                bit dd;
                i = 0; bud = 0; dd = 0;
                while (i < n && bud < 2000) begin
                    if (dup && i == 1 && !dd) begin
                        cmd_go = 1; rd_base = 7'h00; rd_len = 8'd0; load_base = 7'h33; dd = 1;
                    end else cmd_go = 0;
                    if ($urandom_range(3) == 0) in_valid = 0;
                    else begin
                        in_valid = 1; in_data = jd[i]; in_last = (i == n - 1);
                        if (in_ready) i++;
                    end
                    @(negedge clock);
                    bud++;
                end
                in_valid = 0; in_last = 0; cmd_go = 0;
                if (i < n) check("load_stalled", i, n);
            end
            begin
                int bud, wt;
                logic [7:0] held;
                bit hv;
                bud = 0; wt = 0; hv = 0; held = 0;
                while (!seen && bud < 4000) begin
                    @(negedge clock);
                    bud++;
                    if (job_done) begin
                        seen = 1;
                        if (gad) cmd_go = 1;
                    end else if (out_valid) begin
                        if (hv) check("out_stable", out_data, held);
                        if (bp > 0) out_ready = (wt >= bp);
                        else out_ready = ($urandom_range(1) == 1);
                        if (out_ready) begin
                            got.push_back(out_data); lastq.push_back(out_last); hv = 0; wt = 0;
                        end else begin
                            hv = 1; held = out_data; wt++;
                        end
                    end else begin
                        out_ready = (bp == 0) && ($urandom_range(1) == 1);
                        hv = 0;
                    end
                end
                out_ready = 0;
            end
        join
        check("job_done_seen", seen, 1);
        @(negedge clock);
        cmd_go = 0;
        check("done_one_cycle", {job_done, busy, in_ready}, 0);
        check("wr_count", wlog.size(), n);
        for (int i = 0; i < n; i++) begin
            check("wr_beat", (i < wlog.size()) ? wlog[i] : 19'h0, {4'd8, 7'(lb + i), jd[i]});
            ref_mem[7'(lb + i)] = jd[i];
        end
        check("start_pulses", start_cnt - s0, 1);
        check("cycles", cycles, exp_cyc);
        check("timeout", timeout, exp_tmo);
        nrd = exp_tmo ? 0 : rl;
        check("rd_issues", rlog.size() - r0, nrd);
        check("rd_count", got.size(), nrd);
        for (int i = 0; i < nrd && i < got.size(); i++) begin
            check("rd_addr", rlog[r0 + i], 7'(rb + i));
            check("rd_data", got[i], ref_mem[7'(rb + i)]);
            check("rd_last", lastq[i], i == nrd - 1);
        end
    endtask

    typedef struct {
        logic [6:0] lb; int n; logic [6:0] rb; int rl; int dly; int bp;
        bit dup; bit gad; int exp_cyc; bit exp_tmo;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_byte(i);
        //            lb     n  rb     rl dly bp dup gad cyc  tmo
        tbl[0] = '{7'h10, 4, 7'h20, 3, 37, 0, 0, 0,  38, 0};
        tbl[1] = '{7'h7E, 4, 7'h7E, 4,  1, 5, 0, 0,   2, 0};
        tbl[2] = '{7'h30, 1, 7'h00, 0,  5, 0, 0, 1,   6, 0};
        tbl[3] = '{7'h40, 2, 7'h10, 4,  0, 0, 0, 0, 100, 1};
        tbl[4] = '{7'h50, 3, 7'h50, 3, 10, 0, 1, 0,  11, 0};

        repeat (3) @(negedge clock);
        check_idle("reset_state");
        reset = 1;
        repeat (2) @(negedge clock);

        for (int k = 0; k < 5; k++) begin
            jd.delete();
            if (k == 0) jd = '{8'h11, 8'h22, 8'h33, 8'h44};
            else for (int i = 0; i < tbl[k].n; i++) jd.push_back(8'($urandom));
            run_job(tbl[k].lb, tbl[k].n, tbl[k].rb, tbl[k].rl, tbl[k].dly, tbl[k].bp,
                    tbl[k].dup, tbl[k].gad, tbl[k].exp_cyc, tbl[k].exp_tmo);
        end

        // Reset while a read is outstanding at the slave.
        begin
            int bud;
            done_delay = 2;
            @(negedge clock);
            cmd_go = 1; load_base = 7'h60; rd_base = 7'h60; rd_len = 8'd2;
            @(negedge clock);
            cmd_go = 0; in_valid = 1; in_data = 8'hC3; in_last = 1;
            @(negedge clock);
            in_valid = 0; in_last = 0;
            ref_mem[7'h60] = 8'hC3;
            bud = 0;
            while (!acc.S_oe_ram[0] && bud < 50) begin
                @(negedge clock);
                bud++;
            end
            check("mid_reset_reached_read", acc.S_oe_ram[0], 1);
            @(negedge clock);
            reset = 0;
            #1;
            check_idle("mid_reset");
            @(negedge clock);
            reset = 1;
            repeat (2) @(negedge clock);
            check_idle("after_reset");
        end

        jd.delete();
        for (int i = 0; i < 2; i++) jd.push_back(8'($urandom));
        run_job(7'h61, 2, 7'h60, 3, 4, 0, 1, 0, 5, 0);

        for (int k = 0; k < 8; k++) begin
            int n, rl, dly;
            logic [6:0] lb, rb;
            n = $urandom_range(6, 1);
            rl = $urandom_range(6, 0);
            lb = 7'($urandom);
            rb = 7'($urandom);
            dly = ($urandom_range(7) == 0) ? 0 : $urandom_range(60, 1);
            jd.delete();
            for (int i = 0; i < n; i++) jd.push_back(8'($urandom));
            run_job(lb, n, rb, rl, dly, 0, 0, 0, (dly == 0) ? TMO : dly + 1, dly == 0);
        end

        check("slave_bus_rules", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
